key_search_controller: RTL and testbench

// - Upstream controller for the RC4 decryption datapath. It steps a secret key from KEY_START to KEY_LAST.
// - For each key it runs one datapath pass using a start/done/done_ack handshake.
// - After each pass it scans the decrypted message in D memory through a dedicated read port.
// - It stops on the first key whose plaintext is all lowercase/space (found), or when keys are exhausted (failed).

---
 rtl/key_search_controller_pkg.sv | 27 ++
 rtl/key_search_controller_if.sv | 33 +++
 rtl/key_search_controller.sv | 99 +++++++++
 tb/tb_key_search_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_search_controller_pkg.sv
// Shared types and helpers for the RC4 key search controller.
package key_search_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START_DP  = 4'd1,
    WAIT_DP   = 4'd2,
    ACK_DP    = 4'd3,
    WAIT_DROP = 4'd4,
    CHK_ADDR  = 4'd5,
    CHK_WAIT  = 4'd6,
    CHK_DATA  = 4'd7,
    NEXT_KEY  = 4'd8,
    FOUND     = 4'd9,
    FAILED    = 4'd10
  } ks_state_t;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // A plaintext byte is acceptable if it is a lowercase letter or a space.
  function automatic logic is_valid_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/key_search_controller_if.sv
// Datapath handshake and D-memory read port between controller and datapath.
// Handshake: datapath_start is a one-cycle pulse that launches a pass while
// input_key is stable; datapath_done is a level held by the datapath until
// the controller returns a one-cycle datapath_done_ack; the controller then
// waits for datapath_done to fall before reading D memory (1-cycle latency).
interface key_search_if #(
  parameter int KEY_WIDTH = 10
);
  logic                 datapath_start;
  logic [KEY_WIDTH-1:0] input_key;
  logic                 datapath_done;
  logic                 datapath_done_ack;
  logic [7:0]           d_mem_rd_addr;
  logic [7:0]           d_mem_rd_data;

  modport master (
    output datapath_start,
    output input_key,
    input  datapath_done,
    output datapath_done_ack,
    output d_mem_rd_addr,
    input  d_mem_rd_data
  );

  modport slave (
    input  datapath_start,
    input  input_key,
    output datapath_done,
    input  datapath_done_ack,
    input  d_mem_rd_addr,
    output d_mem_rd_data
  );
endinterface

// File: rtl/key_search_controller.sv
// Steps the key from KEY_START to KEY_LAST, runs one datapath pass per key,
// then scans MSG_LEN decrypted bytes; stops on the first all-valid plaintext.
module key_search_controller
  import key_search_pkg::*;
#(
  parameter int KEY_WIDTH = 10,
  parameter int KEY_START = 0,
  parameter int KEY_LAST  = 2**KEY_WIDTH - 1,
  parameter int MSG_LEN   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       search_start,
  key_search_if.master dp,
  output logic       busy,
  output logic       found,
  output logic       failed,
  output ks_state_t  state
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  ks_state_t  next_state;
  logic [IDX_W-1:0] idx;
  logic       char_ok;
  logic       last_byte;
  logic       last_key;

  assign char_ok   = is_valid_char(dp.d_mem_rd_data);
  assign last_byte = (idx == IDX_W'(MSG_LEN - 1));
  assign last_key  = (dp.input_key == KEY_WIDTH'(KEY_LAST));

  // State register plus the key counter, byte index and read address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      dp.input_key     <= KEY_WIDTH'(KEY_START);
      dp.d_mem_rd_addr <= 8'd0;
      idx              <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE, FOUND, FAILED: if (search_start) dp.input_key <= KEY_WIDTH'(KEY_START);
        ACK_DP:   idx <= '0;
        CHK_ADDR: dp.d_mem_rd_addr <= 8'(idx);
        CHK_DATA: if (char_ok && !last_byte) idx <= idx + 1'b1;
        // KEY_LAST is tested before incrementing, so the key never wraps.
        NEXT_KEY: if (!last_key) dp.input_key <= dp.input_key + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state decode and state-derived pulse/status outputs.
  always_comb begin
    next_state           = state;
    dp.datapath_start    = 1'b0;
    dp.datapath_done_ack = 1'b0;
    busy                 = 1'b1;
    found                = 1'b0;
    failed               = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (search_start) next_state = START_DP;
      end
      START_DP: begin
        dp.datapath_start = 1'b1;
        next_state        = WAIT_DP;
      end
      WAIT_DP:   if (dp.datapath_done) next_state = ACK_DP;
      ACK_DP: begin
        dp.datapath_done_ack = 1'b1;
        next_state           = WAIT_DROP;
      end
      WAIT_DROP: if (!dp.datapath_done) next_state = CHK_ADDR;
      CHK_ADDR:  next_state = CHK_WAIT;
      CHK_WAIT:  next_state = CHK_DATA;
      CHK_DATA: begin
        if (!char_ok)       next_state = NEXT_KEY;
        else if (last_byte) next_state = FOUND;
        else                next_state = CHK_ADDR;
      end
      NEXT_KEY:  next_state = last_key ? FAILED : START_DP;
      FOUND: begin
        busy  = 1'b0;
        found = 1'b1;
        if (search_start) next_state = START_DP;
      end
      FAILED: begin
        busy   = 1'b0;
        failed = 1'b1;
        if (search_start) next_state = START_DP;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_search_controller.sv
// Bench for key_search_controller: behavioural datapath + D memory, a
// scoreboard fed by a search-level reference model, and a monitor that
// checks results and handshake behaviour as the DUT presents them.
module tb_key_search_controller;
  import key_search_pkg::*;

  localparam int KW      = 4;
  localparam int NKEYS   = 16;
  localparam int MSG_LEN = 32;
  localparam int EW      = 1 + 1 + KW + 8 + 16;

  logic      clk;
  logic      reset_n;
  logic      search_start;
  logic      busy, found, failed;
  ks_state_t state;

  key_search_if #(.KEY_WIDTH(KW)) bus ();

  key_search_controller #(
    .KEY_WIDTH(KW), .KEY_START(0), .KEY_LAST(NKEYS - 1), .MSG_LEN(MSG_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .search_start(search_start), .dp(bus),
    .busy(busy), .found(found), .failed(failed), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath + memory models ----------------
  logic [7:0]    msg_tab [NKEYS][MSG_LEN];
  int            dp_n    = 5;
  int            dp_hold = 0;
  int            dp_cnt;
  logic          dp_run, dp_drop;
  int            hold_cnt;
  logic [KW-1:0] dp_key;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_run <= 1'b0; dp_drop <= 1'b0; dp_cnt <= 0; hold_cnt <= 0;
      dp_key <= '0; bus.datapath_done <= 1'b0;
    end else begin
      if (bus.datapath_start) begin
        dp_run <= 1'b1; dp_cnt <= dp_n; dp_key <= bus.input_key;
      end else if (dp_run) begin
        if (dp_cnt <= 1) begin bus.datapath_done <= 1'b1; dp_run <= 1'b0; end
        else dp_cnt <= dp_cnt - 1;
      end
      if (bus.datapath_done && bus.datapath_done_ack) begin
        if (dp_hold == 0) bus.datapath_done <= 1'b0;
        else begin dp_drop <= 1'b1; hold_cnt <= dp_hold; end
      end else if (dp_drop) begin
        if (hold_cnt <= 1) begin bus.datapath_done <= 1'b0; dp_drop <= 1'b0; end
        else hold_cnt <= hold_cnt - 1;
      end
    end
  end

  always @(posedge clk) bus.d_mem_rd_data <= msg_tab[dp_key][bus.d_mem_rd_addr[4:0]];

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int resp_cnt = 0;
  int mon_starts = 0;
  int mon_checks = 0;

  // ---------------- reference model ----------------
  function automatic bit ref_valid(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic compute_expect(output logic [EW-1:0] e);
    int chk = 0;
    int st = 0;
    bit f = 0;
    int kf = NKEYS - 1;
    for (int k = 0; k < NKEYS; k++) begin
      int first = MSG_LEN;
      st++;
      for (int i = 0; i < MSG_LEN; i++)
        if (!ref_valid(msg_tab[k][i])) begin first = i; break; end
      if (first == MSG_LEN) begin chk += MSG_LEN; f = 1; kf = k; break; end
      chk += first + 1;
    end
    e = {f, !f, KW'(kf), 8'(st), 16'(chk)};
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] rand_valid();
    int r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_invalid();
    logic [7:0] edges [8] = '{8'h00, 8'h60, 8'h7B, 8'h1F, 8'h21, 8'hFF, 8'h41, 8'h5A};
    logic [7:0] b;
    if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 7)];
    do b = 8'($urandom); while (ref_valid(b));
    return b;
  endfunction

  task automatic fill_valid(input int k);
    for (int i = 0; i < MSG_LEN; i++) msg_tab[k][i] = rand_valid();
  endtask

  task automatic fill_invalid(input int k);
    fill_valid(k);
    msg_tab[k][$urandom_range(0, MSG_LEN - 1)] = rand_invalid();
  endtask

  task automatic all_invalid();
    for (int k = 0; k < NKEYS; k++) fill_invalid(k);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 search_start = 1'b1;
    @(posedge clk); #1 search_start = 1'b0;
  endtask

  // Issue a search with the expected outcome queued; optionally poke a
  // search_start while busy, which must have no effect.
  task automatic run_search(input bit poke);
    logic [EW-1:0] e;
    int r0;
    int n;
    compute_expect(e);
    exp_q.push_back(e);
    r0 = resp_cnt;
    pulse_start();
    if (poke) begin
      repeat ($urandom_range(5, 40)) @(posedge clk);
      #1;
      if (busy) begin
        search_start = 1'b1;
        @(posedge clk); #1 search_start = 1'b0;
      end
    end
    n = 0;
    while (resp_cnt == r0 && n < 20000) begin @(posedge clk); n++; end
    if (resp_cnt == r0) begin
      tests++; fails++;
      $display("FAIL search_timeout: no completion after %0d cycles, need busy to fall", n);
      exp_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic prev_busy = 1'b0;
    logic prev_ack = 1'b0;
    ks_state_t prev_state = IDLE;
    logic [EW-1:0] e, got;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_busy = 1'b0; prev_ack = 1'b0; prev_state = IDLE;
        mon_starts = 0; mon_checks = 0;
      end else begin
        if (bus.datapath_start) mon_starts++;
        if (state == CHK_DATA) mon_checks++;
        if (bus.datapath_done_ack) begin
          tests++;
          if (prev_ack || !bus.datapath_done) begin
            fails++;
            $display("FAIL ack_pulse: prev_ack=%0b done=%0b, need prev_ack=0 done=1",
                     prev_ack, bus.datapath_done);
          end
        end
        if (state == CHK_ADDR && prev_state == WAIT_DROP) begin
          tests++;
          if (bus.datapath_done) begin
            fails++;
            $display("FAIL check_before_drop: done=%0b at first check, need 0", bus.datapath_done);
          end
        end
        if (prev_busy && !busy) begin
          got = {found, failed, bus.input_key, 8'(mon_starts), 16'(mon_checks)};
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result: got found=%0b failed=%0b key=%0d, need no completion",
                     found, failed, bus.input_key);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              fails++;
              $display("FAIL search_result: got found=%0b failed=%0b key=%0d starts=%0d checks=%0d, need found=%0b failed=%0b key=%0d starts=%0d checks=%0d",
                       got[EW-1], got[EW-2], got[EW-3 -: KW], got[23:16], got[15:0],
                       e[EW-1], e[EW-2], e[EW-3 -: KW], e[23:16], e[15:0]);
            end
          end
          mon_starts = 0; mon_checks = 0;
          resp_cnt++;
        end
        prev_busy = busy; prev_ack = bus.datapath_done_ack; prev_state = state;
      end
    end
  end

  // ---------------- reset-value check ----------------
  task automatic check_reset(input string name);
    logic [KW+8+5+3:0] got, need;
    got  = {state, bus.input_key, bus.d_mem_rd_addr, busy, found, failed,
            bus.datapath_start, bus.datapath_done_ack};
    need = {IDLE, KW'(0), 8'd0, 5'b0};
    tests++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s: got state=%0d key=%0d addr=%0d busy/found/failed/start/ack=%05b, need all zero",
               name, got[KW+17:KW+14], got[KW+13:14], got[12:5], got[4:0]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string fox;
    int n;
    fox = "the quick brown fox jumps over th";
    search_start = 1'b0;
    reset_n = 1'b0;
    all_invalid();
    repeat (3) @(posedge clk);
    #1 check_reset("reset_values");
    reset_n = 1'b1;

    // Key 0 valid, datapath latency 5.
    dp_n = 5; dp_hold = 0;
    all_invalid(); fill_valid(0);
    run_search(0);

    // Only key 3 decrypts to the pangram prefix.
    dp_n = $urandom_range(1, 10);
    all_invalid();
    for (int i = 0; i < MSG_LEN; i++) msg_tab[3][i] = fox[i];
    run_search(0);

    // No valid key: must fail at the last key without a further start.
    all_invalid();
    run_search(0);

    // Boundary bytes: 7B at the end, 60 at the start, space in the middle.
    all_invalid();
    fill_valid(0); msg_tab[0][MSG_LEN - 1] = 8'h7B;
    fill_valid(1); msg_tab[1][0] = 8'h60;
    fill_valid(2); msg_tab[2][5] = 8'h20;
    run_search(0);

    // done held for 3 cycles after the ack.
    dp_hold = 3; dp_n = 4;
    all_invalid(); fill_valid(1);
    run_search(0);

    // Randomized searches.
    for (int r = 0; r < 6; r++) begin
      dp_n = $urandom_range(1, 12);
      dp_hold = $urandom_range(0, 4);
      for (int k = 0; k < NKEYS; k++)
        if ($urandom_range(0, 7) == 0) fill_valid(k); else fill_invalid(k);
      run_search(1);
    end

    // Reset while waiting on the memory, then a clean restart at key 0.
    dp_n = 3; dp_hold = 0;
    all_invalid(); fill_valid(0); fill_valid(1); msg_tab[0][20] = 8'h00;
    pulse_start();
    n = 0;
    while (state != CHK_WAIT && n < 2000) begin @(negedge clk); n++; end
    tests++;
    if (state != CHK_WAIT) begin
      fails++;
      $display("FAIL reach_chk_wait: state=%0d, need %0d", state, CHK_WAIT);
    end
    #2 reset_n = 1'b0;
    #1 check_reset("async_reset");
    search_start = 1'b1;
    @(posedge clk); #1 search_start = 1'b0;
    check_reset("reset_beats_start");
    @(posedge clk); #1 reset_n = 1'b1;
    fill_valid(0);
    run_search(0);

    // No stray starts once the search has settled.
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (mon_starts != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL idle_quiet: starts=%0d pending=%0d, need 0 and 0", mon_starts, exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
